// File: rtl/mem_burst_adapter.sv
// Whole-line fill/write-back requests become one command plus a BEATS-beat burst; one mem_done per transaction.
// Define MEM_BURST_TIMEOUT_EN to abort a stalled burst after TIMEOUT idle cycles and flag it with mem_err.
module mem_burst_adapter #(
  parameter int LINE_W  = 512,
  parameter int BEAT_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [31:0]       mem_addr,
  input  logic [LINE_W-1:0] mem_write_data,
  output logic [LINE_W-1:0] mem_read_data,
  output logic              mem_done,
  output logic              mem_err,
  output logic              bus_cmd_valid,
  input  logic              bus_cmd_ready,
  output logic              bus_cmd_we,
  output logic [31:0]       bus_cmd_addr,
  output logic [BEAT_W-1:0] bus_wdata,
  output logic              bus_wvalid,
  input  logic              bus_wready,
  input  logic [BEAT_W-1:0] bus_rdata,
  input  logic              bus_rvalid
);

  localparam int BEATS = LINE_W / BEAT_W;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int OFS_W = $clog2(LINE_W / 8);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BEATS - 1);

  typedef enum logic [2:0] {IDLE, CMD, WDATA, RDATA, DONE} state_t;

  state_t            state, state_nx;
  logic [CNT_W-1:0]  cnt;
  logic [LINE_W-1:0] line_q;
  logic [31:0]       addr_q;
  logic              we_q;
  logic              timeout_hit;
  logic              unused_addr_ofs;

  assign unused_addr_ofs = ^mem_addr[OFS_W-1:0];
  assign bus_cmd_addr    = addr_q;
  assign bus_cmd_we      = we_q;

`ifdef MEM_BURST_TIMEOUT_EN
  logic [7:0] idle_cnt;
  logic       err_q;
  logic       active;
  logic       beat_hs;

  assign active  = (state == CMD) || (state == WDATA) || (state == RDATA);
  assign beat_hs = ((state == CMD)   && bus_cmd_ready) ||
                   ((state == WDATA) && bus_wready)    ||
                   ((state == RDATA) && bus_rvalid);
  // Decided one cycle early so that DONE itself is the TIMEOUT-th idle cycle.
  assign timeout_hit = active && !beat_hs && (idle_cnt == 8'(TIMEOUT - 2));
  assign mem_err     = err_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idle_cnt <= '0;
      err_q    <= 1'b0;
    end else begin
      if (beat_hs || !active) idle_cnt <= '0;
      else                    idle_cnt <= idle_cnt + 8'd1;
      if (timeout_hit)                           err_q <= 1'b1;
      else if (state == DONE || state == IDLE)   err_q <= 1'b0;
    end
  end
`else
  localparam int unused_timeout = TIMEOUT;
  assign timeout_hit = 1'b0;
  assign mem_err     = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (mem_write || mem_read) state_nx = CMD;
      CMD:     if (bus_cmd_ready) state_nx = we_q ? WDATA : RDATA;
      WDATA:   if (bus_wready && cnt == LAST) state_nx = DONE;
      RDATA:   if (bus_rvalid && cnt == LAST) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (timeout_hit) state_nx = DONE;
  end

  always_comb begin
    bus_cmd_valid = 1'b0;
    bus_wvalid    = 1'b0;
    bus_wdata     = '0;
    mem_done      = 1'b0;
    case (state)
      CMD:   bus_cmd_valid = 1'b1;
      WDATA: begin
        bus_wvalid = 1'b1;
        bus_wdata  = line_q[BEAT_W*cnt +: BEAT_W];
      end
      DONE:    mem_done = 1'b1;
      default: ;
    endcase
  end

  // Write-back wins when both requests are up; the held read is taken on the next IDLE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q        <= '0;
      we_q          <= 1'b0;
      line_q        <= '0;
      cnt           <= '0;
      mem_read_data <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (mem_write) begin
            addr_q <= {mem_addr[31:OFS_W], OFS_W'(0)};
            line_q <= mem_write_data;
            we_q   <= 1'b1;
          end else if (mem_read) begin
            addr_q <= {mem_addr[31:OFS_W], OFS_W'(0)};
            we_q   <= 1'b0;
          end
        end
        CMD: cnt <= '0;
        WDATA: if (bus_wready) cnt <= cnt + 1'b1;
        RDATA: begin
          if (bus_rvalid) begin
            mem_read_data[BEAT_W*cnt +: BEAT_W] <= bus_rdata;
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
